// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: VGA scan-out fetch, full-buffer clear engine and pixel writer
// share one single-port RAM; scan-out owns every fetch slot, sync/colour are 2-cycle aligned.
module vga_fb_arbiter #(
    parameter int unsigned FB_W   = 160,
    parameter int unsigned FB_H   = 120,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              hs,
    input  logic              vs,
    output logic              hs_out,
    output logic              vs_out,
    output logic [DATA_W-1:0] rgb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_x,
    input  logic [6:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int unsigned H_ACT   = 640;
    localparam int unsigned V_ACT   = 480;
    localparam int unsigned FB_SIZE = FB_W * FB_H;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic              active;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_in_range;
    logic              wr_xfer;
    logic              clr_wr;
    logic              clr_last;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              busy_q;
    logic              done_q;

    logic              active_q, fetch_q, hs_q, vs_q;
    logic              hs_out_q, vs_out_q;
    logic [DATA_W-1:0] hold_q, rgb_q;

    assign active     = (32'(x) < H_ACT) && (32'(y) < V_ACT);
    assign fetch      = active && (x[1:0] == 2'b00);
    assign fetch_addr = ADDR_W'(y >> 2) * ADDR_W'(FB_W) + ADDR_W'(x >> 2);

    assign wr_addr     = ADDR_W'(wr_y) * ADDR_W'(FB_W) + ADDR_W'(wr_x);
    assign wr_in_range = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);
    assign wr_ready    = !reset && (state_q == IDLE) && !fetch;
    assign wr_xfer     = wr_valid && wr_ready;

    assign clr_wr   = !reset && (state_q == CLEAR) && !fetch;
    assign clr_last = clr_wr && (cnt_q == ADDR_W'(FB_SIZE - 1));

    // RAM slot: fetch > clear > writer; an idle slot presents the fetch address
    always_comb begin
        ram_addr  = fetch_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (clr_wr) begin
            ram_addr  = cnt_q;
            ram_we    = 1'b1;
            ram_wdata = color_q;
        end else if (wr_xfer) begin
            ram_addr  = wr_addr;
            ram_we    = wr_in_range;
            ram_wdata = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (clr_wr) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            busy_q  <= (state_d == CLEAR);
            done_q  <= clr_last;
        end
    end

    // Two-stage pixel pipeline; the fetched word is reused for the next 3 pixels
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            fetch_q  <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hold_q   <= '0;
            rgb_q    <= '0;
            hs_out_q <= 1'b1;
            vs_out_q <= 1'b1;
        end else begin
            active_q <= active;
            fetch_q  <= fetch;
            hs_q     <= hs;
            vs_q     <= vs;
            if (fetch_q) begin
                hold_q <= ram_rdata;
            end
            rgb_q    <= !active_q ? '0 : (fetch_q ? ram_rdata : hold_q);
            hs_out_q <= hs_q;
            vs_out_q <= vs_q;
        end
    end

    assign hs_out     = hs_out_q;
    assign vs_out     = vs_out_q;
    assign rgb        = rgb_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter: reset, scan-out, writer and clear engine.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        hs, vs;
    logic        hs_out, vs_out;
    logic [7:0]  rgb;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_data;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        clear_busy, clear_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .hs(hs), .vs(vs),
        .hs_out(hs_out), .vs_out(vs_out), .rgb(rgb),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Inputs change 1 time unit after the active edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic blank_in();
        x = 10'd700; y = 10'd500; hs = 1'b1; vs = 1'b1;
        wr_valid = 1'b0; clear_req = 1'b0; ram_rdata = 8'h00;
    endtask

    initial begin
        int writes, bad, busy_n, done_n, rdy_bad, align_bad, fetch_hit, fa_bad, exp_a, bx, by;
        logic prev_busy;

        blank_in();
        reset = 1'b1; hs = 1'b0; vs = 1'b0;
        wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'h1C; clear_color = 8'h00;

        // Reset held 3 cycles with writer requesting
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("rst_rgb", 32'(rgb), 32'h0);
            chk("rst_hs_out", 32'(hs_out), 32'h1);
            chk("rst_vs_out", 32'(vs_out), 32'h1);
            chk("rst_ram_we", 32'(ram_we), 32'h0);
            chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        end
        cyc(); reset = 1'b0; blank_in();
        cyc(); cyc();

        // Scan-out of word at (2,1): address 162, shown for x=8..11, hsync aligned
        cyc(); x = 10'd8; y = 10'd4; hs = 1'b0; ram_rdata = 8'h33; #1;
        chk("fetch_addr", 32'(ram_addr), 32'd162);
        chk("fetch_we", 32'(ram_we), 32'h0);
        cyc(); x = 10'd9; hs = 1'b1; ram_rdata = 8'hA5; #1;
        chk("rgb_pre_blank", 32'(rgb), 32'h0);
        chk("hs_out_lat1", 32'(hs_out), 32'h1);
        cyc(); x = 10'd10; ram_rdata = 8'h5A; #1;
        chk("rgb_x8", 32'(rgb), 32'hA5);
        chk("hs_out_lat2", 32'(hs_out), 32'h0);
        cyc(); x = 10'd11; #1;
        chk("rgb_x9", 32'(rgb), 32'hA5);
        chk("hs_out_lat3", 32'(hs_out), 32'h1);
        cyc(); x = 10'd640; #1;
        chk("rgb_x10", 32'(rgb), 32'hA5);
        cyc(); x = 10'd641; #1;
        chk("rgb_x11", 32'(rgb), 32'hA5);
        cyc(); blank_in(); #1;
        chk("rgb_x640", 32'(rgb), 32'h0);

        // Writer during blanking
        cyc(); wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd3; wr_data = 8'h1C; #1;
        chk("wr_blank_ready", 32'(wr_ready), 32'h1);
        chk("wr_blank_we", 32'(ram_we), 32'h1);
        chk("wr_blank_addr", 32'(ram_addr), 32'd485);
        chk("wr_blank_wdata", 32'(ram_wdata), 32'h1C);

        // Writer stalled by a fetch, then accepted; out-of-range accepted but dropped
        cyc(); x = 10'd12; y = 10'd0; #1;
        chk("stall_ready", 32'(wr_ready), 32'h0);
        chk("stall_addr", 32'(ram_addr), 32'd3);
        chk("stall_we", 32'(ram_we), 32'h0);
        cyc(); x = 10'd13; #1;
        chk("unstall_ready", 32'(wr_ready), 32'h1);
        chk("unstall_we", 32'(ram_we), 32'h1);
        chk("unstall_addr", 32'(ram_addr), 32'd485);
        cyc(); x = 10'd14; wr_x = 8'd200; #1;
        chk("oor_x_ready", 32'(wr_ready), 32'h1);
        chk("oor_x_we", 32'(ram_we), 32'h0);
        cyc(); x = 10'd15; wr_x = 8'd5; wr_y = 7'd120; #1;
        chk("oor_y_ready", 32'(wr_ready), 32'h1);
        chk("oor_y_we", 32'(ram_we), 32'h0);

        // Clear in blanking; writer wins the request cycle
        cyc(); blank_in(); wr_valid = 1'b1; wr_y = 7'd3; clear_req = 1'b1; clear_color = 8'hFF; #1;
        chk("clr_req_wr_wins_we", 32'(ram_we), 32'h1);
        chk("clr_req_wr_wins_addr", 32'(ram_addr), 32'd485);
        writes = 0; bad = 0; busy_n = 0; done_n = 0; rdy_bad = 0; align_bad = 0; prev_busy = 1'b0;
        for (int i = 0; i < 19300; i++) begin
            cyc(); wr_valid = 1'b0; clear_req = (i == 50); clear_color = 8'h00; #1;
            if (ram_we) begin
                if (32'(ram_addr) != writes || ram_wdata !== 8'hFF) bad++;
                writes++;
            end
            if (clear_busy) begin
                busy_n++;
                if (wr_ready) rdy_bad++;
            end
            if (clear_done) begin
                done_n++;
                if (clear_busy || !prev_busy) align_bad++;
            end
            prev_busy = clear_busy;
        end
        chk("clr_writes", 32'(writes), 32'd19200);
        chk("clr_seq_bad", 32'(bad), 32'd0);
        chk("clr_busy_cycles", 32'(busy_n), 32'd19200);
        chk("clr_done_pulses", 32'(done_n), 32'd1);
        chk("clr_ready_while_busy", 32'(rdy_bad), 32'd0);
        chk("clr_done_align", 32'(align_bad), 32'd0);

        // Clear spanning active video: never on a fetch slot
        bx = 0; by = 0;
        cyc(); clear_req = 1'b1; clear_color = 8'h3C; x = 10'(bx); y = 10'(by); #1;
        chk("act_req_fetch_we", 32'(ram_we), 32'h0);
        writes = 0; bad = 0; done_n = 0; fetch_hit = 0; fa_bad = 0;
        for (int i = 0; i < 30000 && done_n == 0; i++) begin
            cyc();
            clear_req = 1'b0;
            bx++;
            if (bx == 800) begin bx = 0; by = (by + 1) % 525; end
            x = 10'(bx); y = 10'(by); #1;
            if (ram_we) begin
                if (32'(ram_addr) != writes || ram_wdata !== 8'h3C) bad++;
                if (bx < 640 && by < 480 && (bx % 4) == 0) fetch_hit++;
                writes++;
            end
            if (bx < 640 && by < 480 && (bx % 4) == 0)
                if (32'(ram_addr) != (by / 4) * 160 + bx / 4) fa_bad++;
            if (clear_done) done_n++;
        end
        chk("act_writes", 32'(writes), 32'd19200);
        chk("act_seq_bad", 32'(bad), 32'd0);
        chk("act_write_on_fetch", 32'(fetch_hit), 32'd0);
        chk("act_fetch_addr_bad", 32'(fa_bad), 32'd0);
        chk("act_done_pulses", 32'(done_n), 32'd1);

        // Reset after 100 clear writes aborts; a new request restarts at 0
        cyc(); blank_in(); clear_req = 1'b1; clear_color = 8'h77;
        writes = 0;
        for (int i = 0; i < 200 && writes < 100; i++) begin
            cyc(); clear_req = 1'b0; #1;
            if (ram_we) writes++;
        end
        chk("abort_pre_writes", 32'(writes), 32'd100);
        cyc(); reset = 1'b1; #1;
        chk("abort_rst_we", 32'(ram_we), 32'h0);
        chk("abort_rst_ready", 32'(wr_ready), 32'h0);
        cyc(); reset = 1'b0; #1;
        chk("abort_busy", 32'(clear_busy), 32'h0);
        done_n = 0; writes = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            if (clear_done) done_n++;
            if (ram_we) writes++;
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        chk("abort_no_writes", 32'(writes), 32'd0);
        cyc(); clear_req = 1'b1; clear_color = 8'h11;
        cyc(); clear_req = 1'b0; clear_color = 8'h00; #1;
        chk("restart_we", 32'(ram_we), 32'h1);
        chk("restart_addr0", 32'(ram_addr), 32'd0);
        chk("restart_wdata", 32'(ram_wdata), 32'h11);
        cyc(); #1;
        chk("restart_addr1", 32'(ram_addr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Owns the single-port framebuffer RAM and shares it between VGA scan-out and a pixel writer (game logic or CPU) plus an internal clear engine. Takes the raw x/y/hs/vs beam position from the XY timing counter, fetches one 160x120 framebuffer word per 4x4 screen block, and drives pixel colour with sync delayed to stay aligned. Writes and clears use whatever RAM cycles the scan-out does not need.

## Interface
- `FB_W`, default 160: framebuffer width in words.
- `FB_H`, default 120: framebuffer height in words.
- `DATA_W`, default 8: pixel width, RGB 3-3-2.
- `ADDR_W`, default 15: RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- `clk` in 1: pixel clock, 25 MHz. One clock only.
- `reset` in 1: synchronous, active-high.
- `x`, `y` in 10: beam position from the timing counter.
- `hs`, `vs` in 1: active-low syncs from the timing counter, aligned with `x`/`y`.
- `hs_out`, `vs_out` out 1: `hs`/`vs` delayed 2 cycles.
- `rgb` out DATA_W: pixel colour, aligned with `hs_out`/`vs_out`.
- `ram_addr` out ADDR_W, `ram_we` out 1, `ram_wdata` out DATA_W: RAM command, combinational.
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after the address.
- `wr_valid` in 1, `wr_ready` out 1: writer handshake.
- `wr_x` in 8, `wr_y` in 7, `wr_data` in DATA_W: writer word coordinate and data.
- `clear_req` in 1: one-cycle pulse that starts a full-buffer clear.
- `clear_color` in DATA_W: fill value, sampled when the clear starts.
- `clear_busy` out 1: high while a clear is running.
- `clear_done` out 1: one-cycle pulse when a clear finishes.

## Operation
- `active` = `x` < 640 and `y` < 480.
- `fetch` = `active` and `x[1:0]` == 0. On a fetch cycle the RAM slot belongs to scan-out, unconditionally.
- Fetch address = (`y`>>2)*FB_W + (`x`>>2), with `ram_we`=0.
- Slot priority: fetch > clear > writer. One RAM access per cycle.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on `clear_req`. Latches `clear_color` and sets the clear counter to 0.
  - In CLEAR, each non-fetch cycle writes (counter, colour) and increments the counter.
  - After the write to address FB_W*FB_H-1, go to IDLE and pulse `clear_done` on the next cycle.
  - `clear_req` is ignored while in CLEAR.
- Writer handshake:
  - `wr_ready` = IDLE and !`fetch` and !`reset`.
  - A transfer happens when `wr_valid` and `wr_ready` are both high. In that cycle `ram_addr` = `wr_y`*FB_W + `wr_x`, `ram_we`=1, `ram_wdata`=`wr_data`.
  - If `wr_x` >= FB_W or `wr_y` >= FB_H, the transfer is accepted (ready stays high) but dropped: `ram_we`=0.
- Idle slot (no fetch, no clear, no writer): `ram_we`=0 and `ram_addr` holds the fetch address formula.
- Pixel pipeline, for beam data presented in cycle t:
  - Cycle t+1: if the t cycle was a fetch, `hold` <= `ram_rdata`.
  - Same edge: `rgb` <= !active_d1 ? 0 : (fetch_d1 ? `ram_rdata` : `hold`).
  - Each word is therefore shown for 4 horizontal pixels. Rows repeat 4 times because `y`>>2 is used.
- Arithmetic:
  - Address products are computed at ADDR_W bits, unsigned.
  - The clear counter is ADDR_W bits and never wraps, because it stops at FB_W*FB_H-1.

## Timing
- Latency from `x`/`y`/`hs`/`vs` to `rgb`/`hs_out`/`vs_out` is exactly 2 cycles, with no exceptions.
- RAM read latency is assumed to be 1 cycle. `ram_*` outputs are combinational from `x`, `y`, FSM state and writer inputs.
- Reset values: `rgb`=0, `hs_out`=1, `vs_out`=1, `hold`=0, `clear_busy`=0, `clear_done`=0, FSM=IDLE.
- While `reset` is high, `ram_we`=0 and `wr_ready`=0.
- Reset during CLEAR aborts the clear: FSM goes to IDLE, counter goes to 0, no `clear_done`.
- `clear_busy` is registered: high from the cycle after `clear_req` through the cycle of the final write.
- `clear_done` rises with the fall of `clear_busy`.
- `clear_req` in the same cycle as `wr_valid`: the writer wins that cycle only if the slot is free (FSM still IDLE). CLEAR starts the next cycle.
- Throughput in active video: 3 of every 4 cycles are free. During blanking every cycle is free.
- A full clear takes FB_W*FB_H free cycles: 19200 during blanking, more when it spans active video.

## Test plan
- Reset: hold `reset` 3 cycles with `wr_valid`=1 -> `rgb`=0, `hs_out`=`vs_out`=1, `ram_we`=0, `wr_ready`=0 throughout.
- Scan-out:
  - Stimulus: `x`=8, `y`=4, `ram_rdata`=0xA5 on the next cycle.
  - Required: `ram_addr`=162, `ram_we`=0.
  - Required: `rgb`=0xA5 two cycles later, held for `x`=9..11.
  - Required: `x`=640 gives `rgb`=0 two cycles later.
- Writer in blanking: `x`=700, `wr_valid`=1, `wr_x`=5, `wr_y`=3, `wr_data`=0x1C -> `wr_ready`=1, `ram_we`=1, `ram_addr`=485, `ram_wdata`=0x1C.
- Writer stall:
  - Stimulus: `x`=12, `y`=0, `wr_valid`=1.
  - Required at `x`=12: `wr_ready`=0 and the fetch address is 3.
  - Required at `x`=13: `wr_ready`=1.
  - Out of range: `wr_x`=200 -> accepted, `ram_we`=0.
- Clear:
  - Stimulus: `clear_req` with `clear_color`=0xFF during blanking.
  - Required: `clear_busy` for 19200 cycles, writes to addresses 0..19199 with data 0xFF.
  - Required: `clear_done` pulses once, and `wr_ready`=0 throughout.
  - Repeat across active video: no write ever lands on a fetch cycle.
- Reset mid-clear: assert `reset` after 100 clear writes -> `clear_busy`=0, no `clear_done`. A new `clear_req` restarts at address 0.
